// File: rtl/sdram_write.sv
// SDRAM write-path master: pops pixel words from a FWFT FIFO and bursts them
// into bank 0 row by row, yielding the bus at segment end or on refresh.
module sdram_write #(
    parameter int WROW_ADDR_END  = 937,
    parameter int WCOL_MADDR_END = 256,
    parameter int WCOL_FADDR_END = 512
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        wr_trig,
    input  logic        wr_en,
    input  logic        ref_req,
    output logic        wr_req,
    output logic        flag_wr_end,
    output logic [3:0]  wr_cmd,
    output logic [12:0] wr_addr,
    output logic [1:0]  bank_addr,
    output logic        wfifo_rd_en,
    input  logic [23:0] wfifo_rd_data,
    output logic [23:0] wr_data,
    output logic        dq_oe,
    output logic [4:0]  state
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    localparam logic [8:0] COL_M_LAST = 9'(WCOL_MADDR_END - 1);
    localparam logic [8:0] COL_F_LAST = 9'(WCOL_FADDR_END - 1);
    localparam logic [9:0] ROW_LAST   = 10'(WROW_ADDR_END);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_REQ  = 5'b00010,
        S_ACT  = 5'b00100,
        S_WR   = 5'b01000,
        S_PRE  = 5'b10000
    } state_t;

    state_t      st;
    logic        flag_wr;
    logic        seg_end;
    logic [1:0]  act_cnt;
    logic [1:0]  burst_cnt;
    logic [1:0]  pre_cnt;
    logic [9:0]  row_addr;
    logic [6:0]  col_cnt;
    logic [8:0]  col_last;
    logic        burst_done;
    logic        at_row_end;
    logic        at_seg_end;

    // Arbiter handshake: wr_req stays high for every S_REQ cycle and the
    // grant wr_en is only consumed there; the bus is ours until flag_wr_end.
    assign wr_req      = (st == S_REQ);
    assign wfifo_rd_en = (st == S_WR);
    assign bank_addr   = 2'b00;
    assign state       = st;

    // Column of the last word of the current burst.
    assign col_last   = {col_cnt, 2'b11};
    assign burst_done = (st == S_WR) && (burst_cnt == 2'd3);
    assign at_row_end = (col_last == COL_F_LAST);
    assign at_seg_end = (col_last == COL_M_LAST) || at_row_end;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            st          <= S_IDLE;
            flag_wr     <= 1'b0;
            seg_end     <= 1'b0;
            act_cnt     <= 2'd0;
            burst_cnt   <= 2'd0;
            pre_cnt     <= 2'd0;
            row_addr    <= 10'd0;
            col_cnt     <= 7'd0;
            wr_cmd      <= CMD_NOP;
            wr_addr     <= 13'd0;
            wr_data     <= 24'd0;
            dq_oe       <= 1'b0;
            flag_wr_end <= 1'b0;
        end else begin
            wr_cmd      <= CMD_NOP;
            dq_oe       <= 1'b0;
            flag_wr_end <= 1'b0;
            seg_end     <= burst_done && at_seg_end;

            if (seg_end)
                flag_wr <= 1'b0;
            else if (wr_trig)
                flag_wr <= 1'b1;

            act_cnt   <= (st == S_ACT) ? act_cnt + 2'd1 : 2'd0;
            burst_cnt <= (st == S_WR)  ? burst_cnt + 2'd1 : 2'd0;
            pre_cnt   <= (st == S_PRE) ? pre_cnt + 2'd1 : 2'd0;

            // Frame end lands mid-row, so the row-end branch never sees ROW_LAST.
            if (burst_done) begin
                if (row_addr == ROW_LAST && col_last == COL_M_LAST) begin
                    row_addr <= 10'd0;
                    col_cnt  <= 7'd0;
                end else begin
                    col_cnt <= col_cnt + 7'd1;
                    if (at_row_end)
                        row_addr <= row_addr + 10'd1;
                end
            end

            case (st)
                S_IDLE: begin
                    if (wr_trig)
                        st <= S_REQ;
                end
                S_REQ: begin
                    if (wr_en)
                        st <= S_ACT;
                end
                S_ACT: begin
                    if (act_cnt == 2'd0) begin
                        wr_cmd  <= CMD_ACT;
                        wr_addr <= {3'b000, row_addr};
                    end
                    if (act_cnt == 2'd3)
                        st <= S_WR;
                end
                S_WR: begin
                    dq_oe   <= 1'b1;
                    wr_data <= wfifo_rd_data;
                    if (burst_cnt == 2'd0) begin
                        wr_cmd  <= CMD_WR;
                        wr_addr <= {4'b0000, col_cnt, 2'b00};
                    end
                    if (burst_done && (at_seg_end || ref_req))
                        st <= S_PRE;
                end
                S_PRE: begin
                    if (pre_cnt == 2'd0) begin
                        wr_cmd  <= CMD_PRE;
                        wr_addr <= 13'h0400;
                    end
                    if (pre_cnt == 2'd3) begin
                        if (!flag_wr) begin
                            st          <= S_IDLE;
                            flag_wr_end <= 1'b1;
                        end else if (ref_req) begin
                            st          <= S_REQ;
                            flag_wr_end <= 1'b1;
                        end else begin
                            st <= S_ACT;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_write.sv
// Bench for sdram_write: cycle table for the first transaction, then whole
// segments checked against expected command logs and a FIFO word scoreboard.
module tb_sdram_write;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;

    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_REQ  = 5'b00010;
    localparam logic [4:0] ST_ACT  = 5'b00100;
    localparam logic [4:0] ST_WR   = 5'b01000;

    // Last row shortened to 1 so the frame wrap is reachable in a short run.
    localparam int ROW_END = 1;

    logic        sclk;
    logic        s_rst;
    logic        wr_trig;
    logic        wr_en;
    logic        ref_req;
    logic        wr_req;
    logic        flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [1:0]  bank_addr;
    logic        wfifo_rd_en;
    logic [23:0] wfifo_rd_data;
    logic [23:0] wr_data;
    logic        dq_oe;
    logic [4:0]  state;

    int checks = 0;
    int errors = 0;

    sdram_write #(
        .WROW_ADDR_END  (ROW_END),
        .WCOL_MADDR_END (256),
        .WCOL_FADDR_END (512)
    ) dut (
        .sclk          (sclk),
        .s_rst         (s_rst),
        .wr_trig       (wr_trig),
        .wr_en         (wr_en),
        .ref_req       (ref_req),
        .wr_req        (wr_req),
        .flag_wr_end   (flag_wr_end),
        .wr_cmd        (wr_cmd),
        .wr_addr       (wr_addr),
        .bank_addr     (bank_addr),
        .wfifo_rd_en   (wfifo_rd_en),
        .wfifo_rd_data (wfifo_rd_data),
        .wr_data       (wr_data),
        .dq_oe         (dq_oe),
        .state         (state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model and data scoreboard ----------------
    logic [23:0] fifo_idx = 24'd0;
    logic [23:0] exp_q[$];

    assign wfifo_rd_data = 24'h5A0000 + fifo_idx;

    always @(posedge sclk) begin
        if (wfifo_rd_en) begin
            exp_q.push_back(wfifo_rd_data);
            fifo_idx <= fifo_idx + 24'd1;
        end
    end

    always @(negedge sclk) begin
        if (!s_rst && dq_oe) begin
            if (exp_q.size() == 0)
                check("wr_data underflow", 32'd1, 32'd0);
            else
                check("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- command monitor ----------------
    typedef struct packed {
        logic [3:0]  cmd;
        logic [12:0] addr;
    } cmd_t;

    cmd_t cmd_log[$];
    cmd_t exp_cmds[$];

    always @(negedge sclk) begin
        if (!s_rst && wr_cmd != NOP)
            cmd_log.push_back('{cmd: wr_cmd, addr: wr_addr});
    end

    task automatic exp_push(input logic [3:0] cmd, input int addr);
        exp_cmds.push_back('{cmd: cmd, addr: 13'(addr)});
    endtask

    task automatic exp_seg(input int row, input int c0, input int c1);
        exp_push(ACT, row);
        for (int c = c0; c <= c1; c += 4)
            exp_push(WR, c);
        exp_push(PRE, 'h400);
    endtask

    task automatic compare_log(input string name);
        check({name, " cmd count"}, 32'(cmd_log.size()), 32'(exp_cmds.size()));
        for (int i = 0; i < exp_cmds.size() && i < cmd_log.size(); i++)
            check($sformatf("%s cmd%0d", name, i), 32'(cmd_log[i]), 32'(exp_cmds[i]));
        cmd_log.delete();
        exp_cmds.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_seg();
        cmd_log.delete();
        exp_cmds.delete();
        wr_trig = 1'b1;
        wr_en   = 1'b1;
        @(negedge sclk);
        wr_trig = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge sclk);
            if (flag_wr_end) ok = 1'b1;
        end
        check({name, " flag_wr_end seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_wr_col(input string name, input int col);
        bit ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge sclk);
            if (wr_cmd == WR && wr_addr == 13'(col)) ok = 1'b1;
        end
        check({name, " WR seen"}, 32'(ok), 32'd1);
    endtask

    // Idle at segment end, with a single-cycle flag_wr_end pulse.
    task automatic check_seg_tail(input string name);
        check({name, " state at end"}, 32'(state), 32'(ST_IDLE));
        @(negedge sclk);
        check({name, " flag_wr_end pulse width"}, 32'(flag_wr_end), 32'd0);
        check({name, " idle after end"}, 32'(state), 32'(ST_IDLE));
    endtask

    // ---------------- cycle table for the first transaction ----------------
    typedef struct {
        logic       trig;
        logic       en;
        logic       rfr;
        logic       exp_req;
        logic [3:0] exp_cmd;
        int         exp_addr;
        logic       exp_rd;
        logic       exp_oe;
        logic [4:0] exp_st;
    } vec_t;

    vec_t vecs[11];

    initial begin
        s_rst   = 1'b1;
        wr_trig = 1'b0;
        wr_en   = 1'b0;
        ref_req = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, NOP, 0, 1'b0, 1'b0, ST_REQ};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, NOP, 0, 1'b0, 1'b0, ST_ACT};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, ACT, 0, 1'b0, 1'b0, ST_ACT};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, NOP, 0, 1'b0, 1'b0, ST_ACT};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, NOP, 0, 1'b0, 1'b0, ST_ACT};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, NOP, 0, 1'b1, 1'b0, ST_WR};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, WR,  0, 1'b1, 1'b1, ST_WR};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, NOP, 0, 1'b1, 1'b1, ST_WR};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, NOP, 0, 1'b1, 1'b1, ST_WR};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, NOP, 0, 1'b1, 1'b1, ST_WR};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, WR,  4, 1'b1, 1'b1, ST_WR};

        // Reset state
        repeat (3) @(negedge sclk);
        check("rst state", 32'(state), 32'(ST_IDLE));
        check("rst wr_cmd", 32'(wr_cmd), 32'(NOP));
        check("rst wr_addr", 32'(wr_addr), 32'd0);
        check("rst wr_data", 32'(wr_data), 32'd0);
        check("rst dq_oe", 32'(dq_oe), 32'd0);
        check("rst flag_wr_end", 32'(flag_wr_end), 32'd0);
        check("rst wr_req", 32'(wr_req), 32'd0);
        check("rst wfifo_rd_en", 32'(wfifo_rd_en), 32'd0);
        check("rst bank_addr", 32'(bank_addr), 32'd0);
        s_rst = 1'b0;
        cmd_log.delete();

        // First transaction, cycle by cycle
        for (int i = 0; i < 11; i++) begin
            wr_trig = vecs[i].trig;
            wr_en   = vecs[i].en;
            ref_req = vecs[i].rfr;
            @(negedge sclk);
            check($sformatf("vec%0d wr_req", i), 32'(wr_req), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d wr_cmd", i), 32'(wr_cmd), 32'(vecs[i].exp_cmd));
            if (vecs[i].exp_cmd != NOP)
                check($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d wfifo_rd_en", i), 32'(wfifo_rd_en), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d dq_oe", i), 32'(dq_oe), 32'(vecs[i].exp_oe));
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_st));
        end

        // Segment A: rest of row 0 first half, uninterrupted
        wait_end("segA");
        exp_seg(0, 0, 252);
        compare_log("segA");
        check_seg_tail("segA");

        // Segment B: row 0 second half, row advances afterwards
        start_seg();
        wait_end("segB");
        exp_seg(0, 256, 508);
        compare_log("segB");
        check_seg_tail("segB");

        // Segment C: last row first half, frame wraps to row 0 col 0
        start_seg();
        wait_end("segC");
        exp_seg(ROW_END, 0, 252);
        compare_log("segC");
        check_seg_tail("segC");

        // Segment D: refresh raised at burst_cnt=1 of the col-40 burst
        start_seg();
        wait_wr_col("segD col40", 40);
        ref_req = 1'b1;
        wr_en   = 1'b0;
        wait_end("segD refresh");
        check("segD state after refresh", 32'(state), 32'(ST_REQ));
        check("segD wr_req after refresh", 32'(wr_req), 32'd1);
        ref_req = 1'b0;
        repeat (3) @(negedge sclk);
        check("segD waiting state", 32'(state), 32'(ST_REQ));
        check("segD waiting wr_cmd", 32'(wr_cmd), 32'(NOP));
        check("segD waiting dq_oe", 32'(dq_oe), 32'd0);
        wr_en = 1'b1;
        wait_end("segD resume");
        exp_push(ACT, 0);
        for (int c = 0; c <= 40; c += 4)
            exp_push(WR, c);
        exp_push(PRE, 'h400);
        exp_seg(0, 44, 252);
        compare_log("segD");
        check_seg_tail("segD");

        // Segment E: synchronous reset mid-burst
        start_seg();
        wait_wr_col("segE col264", 264);
        s_rst = 1'b1;
        @(negedge sclk);
        check("mid rst wr_cmd", 32'(wr_cmd), 32'(NOP));
        check("mid rst dq_oe", 32'(dq_oe), 32'd0);
        check("mid rst wfifo_rd_en", 32'(wfifo_rd_en), 32'd0);
        check("mid rst state", 32'(state), 32'(ST_IDLE));
        check("mid rst wr_req", 32'(wr_req), 32'd0);
        s_rst = 1'b0;
        exp_q.delete();

        // After reset the address counters restart at row 0 col 0
        start_seg();
        wait_end("segF");
        exp_seg(0, 0, 252);
        compare_log("segF");
        check_seg_tail("segF");

        check("data queue drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
